onehot128_encoder: RTL and testbench
====================================

ONEHOT128_ENCODER -- requirements
Module: onehot128_encoder

Interface
REQ-001 Parameter: PRIORITY_HIGH, default 1, 1 = highest set bit index wins, 0 = lowest set bit index wins.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 X3  input  32  vector bits [127:96].
REQ-005 X2  input  32  vector bits [95:64].
REQ-006 X1  input  32  vector bits [63:32].
REQ-007 X0  input  32  vector bits [31:0].
REQ-008 in_valid  input  1  X3..X0 hold a vector to encode.
REQ-009 in_ready  output  1  block can accept a vector; high exactly when state is IDLE.
REQ-010 A  output  7  encoded bit index, 0..127.
REQ-011 zero  output  1  accepted vector had no bits set.
REQ-012 multi  output  1  accepted vector had two or more bits set.
REQ-013 out_valid  output  1  A/zero/multi are valid; high exactly when state is HOLD.
REQ-014 out_ready  input  1  consumer takes the result.

Function
REQ-015 The block SHALL be the inverse of the team's 7-to-128 one-hot decoder: for an input of exactly bit i set, it SHALL produce A=i, zero=0, multi=0.
REQ-016 FSM states SHALL be IDLE, SCAN, HOLD; transitions: IDLE->SCAN on in_valid&&in_ready, SCAN->HOLD after fourth word, HOLD->IDLE on out_ready; no other transitions.
REQ-017 On acceptance the block SHALL register all 128 input bits, clear the running count and hit flag, and set the word counter to 3 (PRIORITY_HIGH=1) or 0 (PRIORITY_HIGH=0); inputs are ignored in all other cycles.
REQ-018 In SCAN the block SHALL process exactly one 32-bit word per cycle, counter stepping 3,2,1,0 (or 0,1,2,3), always all four words, regardless of early hits.
REQ-019 Per word: running bit count SHALL accumulate saturating at 2; first nonzero word visited SHALL set hit and record A = word*32 + position of highest (PRIORITY_HIGH=1) or lowest (0) set bit in that word; later words SHALL NOT change A.
REQ-020 Latency: vector accepted at edge N SHALL give out_valid=1 after edge N+4, fixed for every input value.
REQ-021 Result flags: zero=1 and A=0 when count=0; multi=1 when count=2 (saturated); otherwise both 0.
REQ-022 In HOLD, A, zero, multi SHALL remain stable until the edge where out_ready is sampled high; out_valid SHALL fall after that edge.
REQ-023 in_ready SHALL be 0 in SCAN and HOLD; in_valid in those states SHALL have no effect; minimum accept-to-accept spacing is 6 cycles.
REQ-024 A, zero, multi SHALL hold their last values in IDLE and SCAN until the next HOLD entry overwrites them.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, A=0, zero=0, multi=0, out_valid=0, word counter/count/hit cleared, so in_ready=1.
REQ-026 Reset asserted during SCAN or HOLD SHALL discard the transaction in flight; no partial result is ever presented.
REQ-027 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be an accept.

Verification
REQ-028 Reset, X0=0x00000001, others 0, in_valid one cycle, out_ready=1 -> out_valid exactly 4 edges after accept, A=0, zero=0, multi=0.
REQ-029 Sweep i=0..127 with vector 1<<i (split X3..X0 as decoder output) -> A=i, zero=0, multi=0 for every i; chain with the 7-to-128 decoder gives A_out=A_in for all 128 values.
REQ-030 X3=0x80000000, X0=0x00000001 -> PRIORITY_HIGH=1: A=127, multi=1; PRIORITY_HIGH=0: A=0, multi=1.
REQ-031 All words 0 -> zero=1, multi=0, A=0 after 4-cycle latency; X2=0x00000003 -> A=65 (HIGH) / 64 (LOW), multi=1.
REQ-032 out_ready held 0 for 10 cycles in HOLD with in_valid toggling and X changing -> A/zero/multi stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle.
REQ-033 rst_n pulsed low at second SCAN cycle -> out_valid=0 and in_ready=1 immediately; next vector 1<<42 -> A=42 with normal latency.

Source files
------------

// File: rtl/onehot128_encoder_if.sv
// Handshake bus for the 128-bit one-hot encoder.
// The master drives a vector and takes the result; the slave is the encoder.
interface onehot128_encoder_if;
  logic [31:0] X3;
  logic [31:0] X2;
  logic [31:0] X1;
  logic [31:0] X0;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  A;
  logic        zero;
  logic        multi;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output X3, X2, X1, X0, in_valid, out_ready,
    input  in_ready, A, zero, multi, out_valid
  );

  modport slave (
    input  X3, X2, X1, X0, in_valid, out_ready,
    output in_ready, A, zero, multi, out_valid
  );
endinterface

// File: rtl/onehot128_encoder.sv
// 128-to-7 one-hot encoder, inverse of the 7-to-128 decoder.
// A captured vector is scanned one 32-bit word per cycle (always four words),
// so the result appears a fixed four edges after acceptance. Besides the index
// it reports an empty vector (zero) and a vector with several bits set (multi).
module onehot128_encoder #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot128_encoder_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Scan order: top word first when the highest index wins, so the first
  // nonzero word visited always holds the winning bit.
  localparam logic [1:0] FIRST_WORD = PRIORITY_HIGH ? 2'd3 : 2'd0;
  localparam logic [1:0] LAST_WORD  = PRIORITY_HIGH ? 2'd0 : 2'd3;

  logic [1:0]   state;
  logic [127:0] vec_q;
  logic [1:0]   word_idx;
  logic [1:0]   bit_cnt;
  logic         hit;
  logic [6:0]   a_run;
  logic [6:0]   a_q;
  logic         zero_q;
  logic         multi_q;

  logic         accept;
  logic [31:0]  word;
  logic [1:0]   cnt_next;
  logic         hit_next;
  logic [6:0]   a_next;

  // Number of set bits in a word, clipped at 2.
  function automatic logic [1:0] cnt_sat2(input logic [31:0] w);
    if (w == 32'd0)
      return 2'd0;
    else if ((w & (w - 32'd1)) != 32'd0)
      return 2'd2;
    else
      return 2'd1;
  endfunction

  // Add two counts, saturating at 2.
  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

  // Position of the highest (or lowest) set bit within a word.
  function automatic logic [4:0] find_pos(input logic [31:0] w);
    logic [4:0] p;
    p = 5'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 32; i++)
        if (w[i]) p = 5'(i);
    end else begin
      for (int i = 31; i >= 0; i--)
        if (w[i]) p = 5'(i);
    end
    return p;
  endfunction

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.A         = a_q;
  assign bus.zero      = zero_q;
  assign bus.multi     = multi_q;

  // Per-word scan step: the word under the counter updates count, hit and index.
  always_comb begin
    word     = vec_q[{word_idx, 5'd0} +: 32];
    cnt_next = sat_add2(bit_cnt, cnt_sat2(word));
    hit_next = hit | (word != 32'd0);
    a_next   = a_run;
    if (!hit && (word != 32'd0))
      a_next = {word_idx, find_pos(word)};
  end

  // Input vector capture on acceptance; held untouched while scanning.
  always_ff @(posedge clk) begin
    if (accept)
      vec_q <= {bus.X3, bus.X2, bus.X1, bus.X0};
  end

  // IDLE -> SCAN -> HOLD -> IDLE control, scan accumulators and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= 2'd0;
      bit_cnt  <= 2'd0;
      hit      <= 1'b0;
      a_run    <= 7'd0;
      a_q      <= 7'd0;
      zero_q   <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SCAN;
            word_idx <= FIRST_WORD;
            bit_cnt  <= 2'd0;
            hit      <= 1'b0;
            a_run    <= 7'd0;
          end
        end
        SCAN: begin
          bit_cnt  <= cnt_next;
          hit      <= hit_next;
          a_run    <= a_next;
          word_idx <= PRIORITY_HIGH ? (word_idx - 2'd1) : (word_idx + 2'd1);
          if (word_idx == LAST_WORD) begin
            state   <= HOLD;
            a_q     <= (cnt_next == 2'd0) ? 7'd0 : a_next;
            zero_q  <= (cnt_next == 2'd0);
            multi_q <= (cnt_next == 2'd2);
          end
        end
        HOLD: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot128_encoder.sv
// Bench for onehot128_encoder: two instances (highest-wins and lowest-wins)
// driven in lockstep and compared with a bit-counting reference model.
module tb_onehot128_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  onehot128_encoder_if ifh ();
  onehot128_encoder_if ifl ();

  onehot128_encoder #(.PRIORITY_HIGH(1'b1)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(ifh));
  onehot128_encoder #(.PRIORITY_HIGH(1'b0)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(ifl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count set bits over the whole vector, pick the global highest or lowest.
  function automatic void ref_model(input logic [127:0] v, input bit hi,
                                    output logic [6:0] a, output logic z, output logic m);
    int n;
    int idx;
    n   = 0;
    idx = -1;
    for (int i = 0; i < 128; i++) begin
      if (v[i]) begin
        n++;
        if (hi || idx < 0) idx = i;
      end
    end
    z = (n == 0);
    m = (n >= 2);
    a = (n == 0) ? 7'd0 : idx[6:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [127:0] v, input logic iv);
    ifh.X3 = v[127:96]; ifh.X2 = v[95:64]; ifh.X1 = v[63:32]; ifh.X0 = v[31:0];
    ifl.X3 = v[127:96]; ifl.X2 = v[95:64]; ifl.X1 = v[63:32]; ifl.X0 = v[31:0];
    ifh.in_valid = iv;
    ifl.in_valid = iv;
  endtask

  task automatic set_out_ready(input logic r);
    ifh.out_ready = r;
    ifl.out_ready = r;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    logic [127:0] one;
    one = 128'd1;
    case ($urandom_range(0, 3))
      0: v = rand128();
      1: v = one << $urandom_range(0, 127);
      2: v = (one << $urandom_range(0, 127)) | (one << $urandom_range(0, 127));
      default: begin
        v = '0;
        v[{$urandom_range(0, 3), 5'd0} +: 32] = $urandom & $urandom;
      end
    endcase
    return v;
  endfunction

  // Full transaction: accept, measure latency, check results, hand the result off.
  task automatic txn(input logic [127:0] v, input string tag);
    logic [6:0] ah, al;
    logic zh, mh, zl, ml;
    int lat;
    ref_model(v, 1'b1, ah, zh, mh);
    ref_model(v, 1'b0, al, zl, ml);
    chk({tag, "_idle_rdy"}, ifh.in_ready, 1);
    drive(v, 1'b1);
    @(posedge clk); #1;
    drive(rand128(), 1'b0);
    chk({tag, "_scan_rdy"}, ifh.in_ready, 0);
    lat = 0;
    while (ifh.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_A_hi"}, ifh.A, ah);
    chk({tag, "_zero_hi"}, ifh.zero, zh);
    chk({tag, "_multi_hi"}, ifh.multi, mh);
    chk({tag, "_vld_lo"}, ifl.out_valid, 1);
    chk({tag, "_A_lo"}, ifl.A, al);
    chk({tag, "_zero_lo"}, ifl.zero, zl);
    chk({tag, "_multi_lo"}, ifl.multi, ml);
    set_out_ready(1'b1);
    @(posedge clk); #1;
    set_out_ready(1'b0);
    chk({tag, "_vld_drop"}, ifh.out_valid, 0);
    chk({tag, "_rdy_back"}, ifh.in_ready, 1);
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] one;
    logic [6:0] ah;
    logic zh, mh;
    checks = 0;
    errors = 0;
    one = 128'd1;
    rst_n = 1'b0;
    drive('0, 1'b0);
    set_out_ready(1'b0);

    // Reset state
    #2;
    chk("rst_in_ready", ifh.in_ready, 1);
    chk("rst_out_valid", ifh.out_valid, 0);
    chk("rst_A", ifh.A, 0);
    chk("rst_zero", ifh.zero, 0);
    chk("rst_multi", ifh.multi, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single bit 0
    txn(128'd1, "x0_bit0");

    // Decoder chain sweep: one-hot of every index must encode back to it
    for (int i = 0; i < 128; i++) begin
      v = one << i;
      txn(v, $sformatf("sweep%0d", i));
    end

    // Priority between extreme bits, empty vector, two adjacent bits in word 2
    txn({32'h80000000, 32'h0, 32'h0, 32'h00000001}, "extremes");
    txn('0, "all_zero");
    txn({32'h0, 32'h00000003, 32'h0, 32'h0}, "x2_three");

    // Randomised vectors
    for (int k = 0; k < 40; k++) begin
      v = rand_vec();
      txn(v, $sformatf("rand%0d", k));
    end

    // Back-pressure in HOLD with noisy inputs
    v = {32'h0, 32'h0, 32'h00010000, 32'h00000400};
    ref_model(v, 1'b1, ah, zh, mh);
    drive(v, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("hold_enter", ifh.out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      drive(rand_vec(), (k % 2 == 0) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      chk($sformatf("hold_A_%0d", k), ifh.A, ah);
      chk($sformatf("hold_zero_%0d", k), ifh.zero, zh);
      chk($sformatf("hold_multi_%0d", k), ifh.multi, mh);
      chk($sformatf("hold_vld_%0d", k), ifh.out_valid, 1);
      chk($sformatf("hold_rdy_%0d", k), ifh.in_ready, 0);
    end
    drive('0, 1'b0);
    set_out_ready(1'b1);
    @(posedge clk); #1;
    set_out_ready(1'b0);
    chk("hold_release_vld", ifh.out_valid, 0);
    chk("hold_release_rdy", ifh.in_ready, 1);
    repeat (6) begin @(posedge clk); #1; end
    chk("hold_no_accept", ifh.out_valid, 0);
    chk("hold_no_accept_rdy", ifh.in_ready, 1);

    // Reset during the second scan cycle discards the transaction
    drive(one << 5, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", ifh.out_valid, 0);
    chk("midrst_rdy", ifh.in_ready, 1);
    chk("midrst_A", ifh.A, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("midrst_no_result", ifh.out_valid, 0);
    txn(one << 42, "after_rst_42");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
